// File: rtl/text_cell_arbiter.sv
// text_cell_arbiter: shares the single-port text cell RAM between video scan
// fetches (top priority, fixed 3-cycle latency) and host bus accesses.
// Ports: i_clk/i_rst; i_vid_req/i_vid_addr -> o_vid_valid/o_vid_data;
// i_host_* -> o_host_ack/o_host_rdata; i_frame_start latches staging config
// to o_scroll_x/o_scroll_y/o_alpha; o_ram_* / i_ram_rdata drive the cell RAM.
module text_cell_arbiter #(
  parameter int              CELL_COUNT = 5376,
  parameter int              ADDR_W     = 13,
  parameter logic [ADDR_W-1:0] REG_BASE = 13'h1F00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic              o_vid_valid,
  output logic [15:0]       o_vid_data,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [15:0]       i_host_wdata,
  output logic              o_host_ack,
  output logic [15:0]       o_host_rdata,
  input  logic              i_frame_start,
  output logic [4:0]        o_scroll_x,
  output logic [4:0]        o_scroll_y,
  output logic [2:0]        o_alpha,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [15:0]       o_ram_wdata,
  input  logic [15:0]       i_ram_rdata
);

  localparam logic [ADDR_W-1:0] LP_CELLS = ADDR_W'(CELL_COUNT);
  localparam logic [ADDR_W-1:0] LP_R0 = REG_BASE;
  localparam logic [ADDR_W-1:0] LP_R1 = REG_BASE + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LP_R2 = REG_BASE + ADDR_W'(2);

  typedef enum logic [1:0] {
    S_IDLE, S_RD1, S_RD2, S_ACK
  } state_t;

  // *0 tags carry a slot with no RAM access whose result is forced to zero
  typedef enum logic [2:0] {
    T_NONE, T_VID, T_VID0, T_HOST, T_HOST0
  } tag_t;

  state_t r_state;
  state_t w_state_nx;
  tag_t   r_tag1;
  tag_t   r_tag2;
  tag_t   w_tag_nx;

  logic [4:0]  r_stg_x;
  logic [4:0]  r_stg_y;
  logic [2:0]  r_stg_a;
  logic [15:0] w_reg_rdata;

  logic w_vid_gnt;
  logic w_host_gnt;
  logic w_vid_ram;
  logic w_host_ram;
  logic w_reg0;
  logic w_reg1;
  logic w_reg2;
  logic w_reg;
  logic w_host_rd;

  assign w_vid_gnt  = i_vid_req;
  assign w_host_gnt = !i_vid_req && i_host_req
                      && (r_state == S_IDLE);
  assign w_vid_ram  = i_vid_addr < LP_CELLS;
  assign w_host_ram = i_host_addr < LP_CELLS;
  assign w_reg0     = i_host_addr == LP_R0;
  assign w_reg1     = i_host_addr == LP_R1;
  assign w_reg2     = i_host_addr == LP_R2;
  assign w_reg      = w_reg0 | w_reg1 | w_reg2;
  // register reads finish in one cycle; all other reads
  // (RAM or unmapped) take the 3-cycle pipeline path
  assign w_host_rd  = w_host_gnt && !i_host_we && !w_reg;

  assign o_host_ack = (r_state == S_ACK);

  always_comb begin
    w_reg_rdata = '0;
    unique case (1'b1)
      w_reg0:  w_reg_rdata = {11'd0, r_stg_x};
      w_reg1:  w_reg_rdata = {11'd0, r_stg_y};
      w_reg2:  w_reg_rdata = {13'd0, r_stg_a};
      default: w_reg_rdata = '0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_host_gnt)
          w_state_nx = w_host_rd ? S_RD1 : S_ACK;
      S_RD1:   w_state_nx = S_RD2;
      S_RD2:   w_state_nx = S_ACK;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_tag_nx = T_NONE;
    if (w_vid_gnt)
      w_tag_nx = w_vid_ram ? T_VID : T_VID0;
    else if (w_host_rd)
      w_tag_nx = w_host_ram ? T_HOST : T_HOST0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_tag1  <= T_NONE;
      r_tag2  <= T_NONE;
    end else begin
      r_state <= w_state_nx;
      r_tag1  <= w_tag_nx;
      r_tag2  <= r_tag1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ram_addr  <= '0;
      o_ram_we    <= 1'b0;
      o_ram_wdata <= '0;
    end else begin
      o_ram_we <= 1'b0;
      if (w_vid_gnt) begin
        if (w_vid_ram)
          o_ram_addr <= i_vid_addr;
      end else if (w_host_gnt && w_host_ram) begin
        o_ram_addr <= i_host_addr;
        o_ram_we   <= i_host_we;
        if (i_host_we)
          o_ram_wdata <= i_host_wdata;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vid_valid  <= 1'b0;
      o_vid_data   <= '0;
      o_host_rdata <= '0;
    end else begin
      o_vid_valid <= (r_tag2 == T_VID) || (r_tag2 == T_VID0);
      if (r_tag2 == T_VID)
        o_vid_data <= i_ram_rdata;
      else if (r_tag2 == T_VID0)
        o_vid_data <= '0;
      if (w_host_gnt && !i_host_we && w_reg)
        o_host_rdata <= w_reg_rdata;
      else if (r_tag2 == T_HOST)
        o_host_rdata <= i_ram_rdata;
      else if (r_tag2 == T_HOST0)
        o_host_rdata <= '0;
    end
  end

  // active copy reads staging before any same-edge staging write
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stg_x    <= '0;
      r_stg_y    <= '0;
      r_stg_a    <= 3'b011;
      o_scroll_x <= '0;
      o_scroll_y <= '0;
      o_alpha    <= 3'b011;
    end else begin
      if (i_frame_start) begin
        o_scroll_x <= r_stg_x;
        o_scroll_y <= r_stg_y;
        o_alpha    <= r_stg_a;
      end
      if (w_host_gnt && i_host_we) begin
        if (w_reg0) r_stg_x <= i_host_wdata[4:0];
        if (w_reg1) r_stg_y <= i_host_wdata[4:0];
        if (w_reg2) r_stg_a <= i_host_wdata[2:0];
      end
    end
  end

endmodule

// File: tb/tb_text_cell_arbiter.sv
// tb_text_cell_arbiter: scoreboard bench for text_cell_arbiter with a
// behavioural RAM and an independent arbitration/config reference model.
module tb_text_cell_arbiter;

  localparam int          CELLS = 5376;
  localparam logic [12:0] RB    = 13'h1F00;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vid_req;
  logic [12:0] i_vid_addr;
  logic        o_vid_valid;
  logic [15:0] o_vid_data;
  logic        i_host_req;
  logic        i_host_we;
  logic [12:0] i_host_addr;
  logic [15:0] i_host_wdata;
  logic        o_host_ack;
  logic [15:0] o_host_rdata;
  logic        i_frame_start;
  logic [4:0]  o_scroll_x;
  logic [4:0]  o_scroll_y;
  logic [2:0]  o_alpha;
  logic [12:0] o_ram_addr;
  logic        o_ram_we;
  logic [15:0] o_ram_wdata;
  logic [15:0] ram_rdata;

  always #5 clk = ~clk;

  text_cell_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr),
    .o_vid_valid(o_vid_valid), .o_vid_data(o_vid_data),
    .i_host_req(i_host_req), .i_host_we(i_host_we),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
    .o_host_ack(o_host_ack), .o_host_rdata(o_host_rdata),
    .i_frame_start(i_frame_start),
    .o_scroll_x(o_scroll_x), .o_scroll_y(o_scroll_y),
    .o_alpha(o_alpha),
    .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          chk;
  } exp_t;

  typedef struct {
    int          due;
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;

  exp_t vq[$];
  exp_t hq[$];
  wr_t  wq[$];

  logic [15:0] ram [CELLS];
  logic [15:0] ref_mem [CELLS];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int busy_until = -1;
  logic [4:0] m_stg_x, m_stg_y, m_act_x, m_act_y;
  logic [2:0] m_stg_a, m_act_a;
  bit ev, eh, ew, done;
  int lat, s_lat;
  logic [15:0] rd, s_rd;

  function automatic logic [15:0] pat(int i);
    return 16'(i * 40503 + 17);
  endfunction

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h cyc=%0d",
                  tag, got, exp, cyc);
  endtask

  // behavioural single-port RAM, one-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) ram[i] <= pat(i);
    end else if (o_ram_we && o_ram_addr < 13'(CELLS)) begin
      ram[o_ram_addr] <= o_ram_wdata;
    end
    ram_rdata <= (o_ram_addr < 13'(CELLS))
                 ? ram[o_ram_addr] : 16'hDEAD;
  end

  // reference model: predicts grants and pushes expectations
  always @(posedge clk) begin
    logic [12:0] a;
    int due;
    logic [15:0] d;
    if (rst) begin
      vq.delete(); hq.delete(); wq.delete();
      for (int i = 0; i < CELLS; i++) ref_mem[i] = pat(i);
      m_stg_x = 0; m_stg_y = 0; m_stg_a = 3'b011;
      m_act_x = 0; m_act_y = 0; m_act_a = 3'b011;
      busy_until = -1;
    end else begin
      if (i_frame_start) begin
        m_act_x = m_stg_x; m_act_y = m_stg_y; m_act_a = m_stg_a;
      end
      if (i_vid_req) begin
        d = 16'h0;
        if (i_vid_addr < 13'(CELLS)) d = ref_mem[i_vid_addr];
        vq.push_back('{cyc + 3, d, 1'b1});
      end else if (i_host_req && cyc > busy_until) begin
        a = i_host_addr;
        d = 16'h0;
        if (i_host_we) begin
          due = cyc + 1;
          if (a < 13'(CELLS)) begin
            ref_mem[a] = i_host_wdata;
            wq.push_back('{cyc + 1, a, i_host_wdata});
          end else if (a == RB) m_stg_x = i_host_wdata[4:0];
          else if (a == RB + 13'd1) m_stg_y = i_host_wdata[4:0];
          else if (a == RB + 13'd2) m_stg_a = i_host_wdata[2:0];
          hq.push_back('{due, 16'h0, 1'b0});
        end else begin
          due = cyc + 3;
          if (a < 13'(CELLS)) d = ref_mem[a];
          else if (a == RB) begin due = cyc + 1; d = {11'd0, m_stg_x}; end
          else if (a == RB + 13'd1) begin due = cyc + 1; d = {11'd0, m_stg_y}; end
          else if (a == RB + 13'd2) begin due = cyc + 1; d = {13'd0, m_stg_a}; end
          hq.push_back('{due, d, 1'b1});
        end
        busy_until = due;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      ev = vq.size() > 0 && vq[0].due == cyc;
      check("vid_valid", o_vid_valid, ev);
      if (ev) begin
        check("vid_data", o_vid_data, vq[0].data);
        void'(vq.pop_front());
      end
      eh = hq.size() > 0 && hq[0].due == cyc;
      check("host_ack", o_host_ack, eh);
      if (eh) begin
        if (hq[0].chk) check("host_rdata", o_host_rdata, hq[0].data);
        void'(hq.pop_front());
      end
      ew = wq.size() > 0 && wq[0].due == cyc;
      check("ram_we", o_ram_we, ew);
      if (ew) begin
        check("ram_waddr", o_ram_addr, wq[0].addr);
        check("ram_wdata", o_ram_wdata, wq[0].data);
        void'(wq.pop_front());
      end
      check("cfg", {o_alpha, o_scroll_y, o_scroll_x},
            {m_act_a, m_act_y, m_act_x});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vid_fetch(input logic [12:0] a);
    i_vid_req = 1'b1;
    i_vid_addr = a;
    tick();
    i_vid_req = 1'b0;
  endtask

  task automatic host_access(input bit we, input logic [12:0] a,
                             input logic [15:0] d, output int l,
                             output logic [15:0] r);
    int c0;
    bit got;
    i_host_req = 1'b1;
    i_host_we = we;
    i_host_addr = a;
    i_host_wdata = d;
    c0 = cyc;
    got = 1'b0;
    l = -1;
    r = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (o_host_ack) begin
        got = 1'b1;
        l = cyc - c0;
        r = o_host_rdata;
      end
    end
    i_host_req = 1'b0;
    check("host_ack_seen", got, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bit saw;
    rst = 1'b1;
    i_vid_req = 0; i_vid_addr = 0;
    i_host_req = 0; i_host_we = 0;
    i_host_addr = 0; i_host_wdata = 0;
    i_frame_start = 0;
    done = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_alpha", o_alpha, 3);
    check("rst_sx", o_scroll_x, 0);
    check("rst_sy", o_scroll_y, 0);
    check("rst_we", o_ram_we, 0);
    check("rst_rdata", o_host_rdata, 0);
    check("rst_ack", o_host_ack, 0);

    // reset in the middle of a host RAM read
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 13'd100;
    tick();
    rst = 1'b1;
    i_host_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      saw |= o_host_ack;
    end
    check("rst_no_ack", saw, 0);
    check("rst2_alpha", o_alpha, 3);
    check("rst2_sy", o_scroll_y, 0);
    check("rst2_we", o_ram_we, 0);

    // RAM write then read-back
    host_access(1, 13'd100, 16'hF141, lat, rd);
    check("wr_lat", lat, 1);
    tick();
    host_access(0, 13'd100, 16'h0, lat, rd);
    check("rd_lat", lat, 3);
    check("rd_data", rd, 16'hF141);

    // video and host collide in the same cycle
    tick();
    fork
      vid_fetch(13'd200);
      host_access(0, 13'd100, 16'h0, lat, rd);
    join
    check("col_lat", lat, 4);
    check("col_data", rd, 16'hF141);

    // staging write coinciding with frame start
    tick();
    fork
      begin i_frame_start = 1'b1; tick(); i_frame_start = 1'b0; end
      host_access(1, RB + 13'd1, 16'd7, lat, rd);
    join
    tick();
    check("sy_hold", o_scroll_y, 0);
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    check("sy_new", o_scroll_y, 7);
    tick();
    host_access(0, RB + 13'd1, 16'h0, lat, rd);
    check("reg_lat", lat, 1);
    check("reg_rd", rd, 16'h0007);
    tick();
    host_access(1, RB, 16'hFFFF, lat, rd);
    tick();
    host_access(1, RB + 13'd2, 16'h0005, lat, rd);
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    check("sx_new", o_scroll_x, 5'h1F);
    check("alpha_new", o_alpha, 3'd5);

    // unmapped host address and out-of-range video
    tick();
    host_access(1, 13'd6000, 16'h1234, lat, rd);
    check("oor_wr_lat", lat, 1);
    tick();
    host_access(0, 13'd6000, 16'h0, lat, rd);
    check("oor_rd_lat", lat, 3);
    check("oor_rd", rd, 16'h0);
    vid_fetch(13'd5376);
    repeat (3) tick();
    vid_fetch(13'h1FFF);
    repeat (4) tick();

    // interleaved stress
    fork
      begin
        for (int v = 0; v < 125; v++) begin
          vid_fetch(13'($urandom_range(0, 5500)));
          repeat (7) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          if ($urandom_range(0, 7) == 0)
            host_access(1, 13'($urandom_range(0, CELLS - 1)),
                        16'($urandom), s_lat, s_rd);
          else if ($urandom_range(0, 15) == 0)
            host_access(0, 13'($urandom_range(CELLS, 8191)),
                        16'h0, s_lat, s_rd);
          else
            host_access(0, 13'($urandom_range(0, CELLS - 1)),
                        16'h0, s_lat, s_rd);
        end
      end
    join
    repeat (6) tick();
    check("queues_empty", vq.size() + hq.size() + wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
